acc_io_bridge: RTL

Memory-mapped I/O bridge directly downstream of the accumulator CPU's memory stage. It consumes the stage's I/O store strobe and data, buffers outgoing words in a transmit FIFO drained over a valid/ready handshake, and captures incoming words from an external device into a receive holding register. It also returns data or status on `IOIn`, which feeds the memory stage's read-data mux.

---
 rtl/acc_io_bridge.sv | 112 +++++++++++
 1 files changed

// File: rtl/acc_io_bridge.sv
// Memory-mapped I/O bridge behind the accumulator CPU memory stage: TX FIFO (`ACC_IO_TX_FIFO_EN`, else one register) plus RX holding register.
// Latency: store to tx_valid 1 cycle, capture to rx_ready low 1 cycle; IOIn is combinational from registered state.
// Backpressure: TX drains on tx_valid & tx_ready, a store into a full, non-popping buffer is dropped and flags tx_ovf; rx_ready low while holding a word.
module acc_io_bridge #(
    parameter int DATA_WIDTH = 16,
    parameter int TX_DEPTH   = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] IOData,
    input  logic                  IOWrite,
    input  logic                  IORead,
    input  logic                  IOSel,
    output logic [DATA_WIDTH-1:0] IOIn,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);

    if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_depth_check
        $error("acc_io_bridge: TX_DEPTH must be a power of two >= 2");
    end

    logic                  tx_full;
    logic                  tx_empty;
    logic                  tx_pop;
    logic                  tx_push;
    logic                  ovf_set;
    logic                  tx_ovf;
    logic                  rx_full;
    logic [DATA_WIDTH-1:0] rx_hold;

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    // A full buffer still takes a store when its head leaves on the same edge.
    assign tx_push  = IOWrite & (!tx_full | tx_pop);
    assign ovf_set  = IOWrite & tx_full & !tx_pop;

`ifdef ACC_IO_TX_FIFO_EN
    localparam int AW = $clog2(TX_DEPTH);

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [DATA_WIDTH-1:0] mem [TX_DEPTH];

    assign tx_empty = (wr_ptr == rd_ptr);
    assign tx_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign tx_data  = tx_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (tx_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) mem[wr_ptr[AW-1:0]] <= IOData;
    end
`else
    logic                  tx_hold_vld;
    logic [DATA_WIDTH-1:0] tx_hold;

    assign tx_empty = !tx_hold_vld;
    assign tx_full  = tx_hold_vld;
    assign tx_data  = tx_hold_vld ? tx_hold : '0;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            tx_hold_vld <= 1'b0;
            tx_hold     <= '0;
        end else if (tx_push) begin
            tx_hold_vld <= 1'b1;
            tx_hold     <= IOData;
        end else if (tx_pop) begin
            tx_hold_vld <= 1'b0;
        end
    end
`endif

    assign rx_ready = !rx_full;
    assign IOIn     = IOSel ? {{(DATA_WIDTH-4){1'b0}}, tx_ovf, tx_empty, tx_full, rx_full}
                            : rx_hold;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            tx_ovf  <= 1'b0;
            rx_full <= 1'b0;
            rx_hold <= '0;
        end else begin
            // A fresh overflow outranks the clear from a status read on the same edge.
            if (ovf_set)
                tx_ovf <= 1'b1;
            else if (IORead && IOSel)
                tx_ovf <= 1'b0;

            if (rx_valid && !rx_full) begin
                rx_full <= 1'b1;
                rx_hold <= rx_data;
            end else if (IORead && !IOSel) begin
                rx_full <= 1'b0;
            end
        end
    end

endmodule
